neighbor_accumulator_buffer: RTL
================================

Name: neighbor_accumulator_buffer

Overview:
- Banked tile accumulator directly downstream of the neighbour-input processor; consumes its BANK_COUNT per-bank write ports (row, column, data, write enable).
- Each accepted write is sign-extended and added, with saturation, into the accumulator for (row, column).
- A drain state machine streams the whole tile out in row-major order over a valid/ready handshake and zeroes each entry as it is read.
- A clear sweep zeroes all storage after reset.

Parameters:
- BANK_COUNT, 32, number of banks; power of two.
- TILE_SIZE, 128, tile edge length; power of two and a multiple of BANK_COUNT.
- ACC_WIDTH, 16, signed accumulator width; at least 9.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- buffer_row_write  input  $clog2(TILE_SIZE) x BANK_COUNT  per-bank write row.
- buffer_column_write  input  $clog2(TILE_SIZE) x BANK_COUNT  per-bank write column.
- buffer_data_write  input  8 x BANK_COUNT  per-bank signed addend.
- buffer_write_enable  input  1 x BANK_COUNT  per-bank write strobe.
- drain_start  input  1  request a tile drain; honoured in IDLE only.
- out_ready  input  1  downstream ready.
- out_valid  output  1  drain element valid.
- out_row  output  $clog2(TILE_SIZE)  row of the current drain element.
- out_column  output  $clog2(TILE_SIZE)  column of the current drain element.
- out_value  output  ACC_WIDTH  accumulated value at (out_row, out_column).
- busy  output  1  high in CLEAR and DRAIN; upstream must hold writes while high.
- drain_done  output  1  one-cycle pulse after the last element is accepted.
- bank_error  output  1  sticky flag; set on a write presented on the wrong bank port.

Behaviour:
- Mapping, decided:
  - bank = (column + (row*3) % BANK_COUNT) % BANK_COUNT.
  - index = row*(TILE_SIZE/BANK_COUNT) + column/BANK_COUNT.
  - ENTRIES = TILE_SIZE*TILE_SIZE/BANK_COUNT entries per bank.
- Reset (asynchronous):
  - State goes to CLEAR; clear_idx=0; out_valid=0, out_row=0, out_column=0, drain_done=0, bank_error=0, busy=1.
  - Storage itself is not reset.
- CLEAR:
  - Each cycle, all banks write 0 at clear_idx, then clear_idx increments.
  - After index ENTRIES-1 the state moves to IDLE (ENTRIES cycles total); busy drops on the first IDLE cycle.
  - Write strobes are ignored.
- IDLE:
  - For each bank b with buffer_write_enable[b]=1: read-modify-write in one cycle, mem[b][index] <= sat(mem[b][index] + sext(data)).
  - Saturation clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - The result is visible to a write on the next cycle; back-to-back writes to the same entry accumulate correctly.
- Bank check: if bank_from_rc(row, column) != b, that write is dropped and bank_error is set. It clears only on reset.
- drain_start in IDLE:
  - Any same-cycle writes are still accumulated.
  - Next cycle: state is DRAIN, out_row=0, out_column=0, out_valid=1.
  - drain_start in CLEAR or DRAIN is ignored.
- DRAIN:
  - out_value is a combinational read of storage at (out_row, out_column); stable while out_valid && !out_ready.
  - On out_valid && out_ready: the entry is written to 0 and out_column increments. On wrap to 0, out_row increments.
  - When (TILE_SIZE-1, TILE_SIZE-1) is accepted: out_valid=0, drain_done=1 for one cycle, state goes to IDLE.
  - Write strobes are ignored (busy=1).
  - Throughput is one element per cycle with out_ready held high; a full drain takes TILE_SIZE^2 cycles.
- Reset during DRAIN or CLEAR aborts the operation and restarts CLEAR.
- State encoding: CLEAR, IDLE, DRAIN. No other states.

Decomposition:
- Package bitfuscnn_buffer_pkg:
  - Functions bank_from_rc and index_from_rc.
  - Localparams ROW_W, IDX_W, ENTRIES.
  - Enum acc_state_t {CLEAR, IDLE, DRAIN}.
  - Saturating-add function sat_add(acc, data8).
- Sub-module accumulator_bank:
  - One bank's ENTRIES x ACC_WIDTH storage.
  - Write port: index, data, enable, mode = accumulate or zero.
  - One combinational read port.
  - Instantiated BANK_COUNT times by a generate loop.
- The top level holds the FSM, counters, bank check and the output mux.

Test Plan:
- Reset, then wait -> busy=1 for exactly 512 cycles, then 0. Drain with out_ready=1 -> 16384 elements, all 0; drain_done pulses once, on the cycle after the last acceptance.
- Write (row 1, col 2, data 5) on bank port 5, twice on consecutive cycles, then drain -> the element at (1,2) reads 10 and all others read 0. A second drain returns all 0 (clear-on-read).
- Write data 0x7F to (0,0) on port 0 for 300 consecutive cycles with ACC_WIDTH=16 -> drain shows 32767 (saturated). Repeat with 0x80 -> -32768.
- Write (1,2) on port 6 -> bank_error=1 and stays set; entry (1,2) drains 0.
- During DRAIN, hold out_ready=0 for 5 cycles at element (0,3) -> out_value, out_row and out_column hold; writes presented meanwhile are ignored.
- Assert reset_n low mid-drain at element (2,7) -> outputs return to reset values, busy=1, CLEAR runs 512 cycles, then drain yields all 0.

Source files
------------

// File: rtl/bitfuscnn_buffer_pkg.sv
// Shared definitions for the neighbour accumulator buffer: default tile
// geometry, bank/index mapping, drain FSM states and the saturating add.
package bitfuscnn_buffer_pkg;

    localparam int DEF_BANK_COUNT = 32;
    localparam int DEF_TILE_SIZE  = 128;
    localparam int DEF_ACC_WIDTH  = 16;

    localparam int ROW_W   = $clog2(DEF_TILE_SIZE);
    localparam int ENTRIES = DEF_TILE_SIZE * DEF_TILE_SIZE / DEF_BANK_COUNT;
    localparam int IDX_W   = 2 * ROW_W - $clog2(DEF_BANK_COUNT);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        DRAIN = 2'd2
    } acc_state_t;

    // Skewed bank assignment so that a column of a tile spreads over banks.
    function automatic int bank_from_rc(input int row, input int col, input int bank_count);
        return (col + (row * 3) % bank_count) % bank_count;
    endfunction

    function automatic int index_from_rc(input int row, input int col,
                                         input int tile_size, input int bank_count);
        return row * (tile_size / bank_count) + col / bank_count;
    endfunction

    // Adds a signed byte to an accumulator and clamps to the signed range of acc_width bits.
    function automatic int sat_add(input int acc, input logic signed [7:0] data8, input int acc_width);
        int sum;
        int hi;
        int lo;
        int res;
        sum = acc + int'(data8);
        hi  = (1 << (acc_width - 1)) - 1;
        lo  = -hi - 1;
        res = sum;
        if (sum > hi) res = hi;
        if (sum < lo) res = lo;
        return res;
    endfunction

endpackage

// File: rtl/accumulator_bank.sv
// One bank of accumulator storage: a single write port that either zeroes
// or saturating-accumulates the addressed entry, plus one combinational read.
module accumulator_bank
    import bitfuscnn_buffer_pkg::*;
#(
    parameter int ENTRY_COUNT = ENTRIES,
    parameter int INDEX_W     = IDX_W,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
    input  logic                        clk_i,
    input  logic [INDEX_W-1:0]          wr_index_i,
    input  logic signed [7:0]           wr_data_i,
    input  logic                        wr_enable_i,
    input  logic                        wr_zero_i,
    input  logic [INDEX_W-1:0]          rd_index_i,
    output logic signed [ACC_WIDTH-1:0] rd_data_o
);

    logic signed [ACC_WIDTH-1:0] mem_q [ENTRY_COUNT];
    logic signed [ACC_WIDTH-1:0] wr_value_d;

    // New value for the addressed entry: zero, or old value plus addend with saturation
    always_comb begin
        wr_value_d = '0;
        if (!wr_zero_i) begin
            wr_value_d = ACC_WIDTH'(sat_add(int'(mem_q[wr_index_i]), wr_data_i, ACC_WIDTH));
        end
    end

    // Storage is deliberately not reset; the top-level clear sweep initialises it
    always_ff @(posedge clk_i) begin
        if (wr_enable_i) begin
            mem_q[wr_index_i] <= wr_value_d;
        end
    end

    assign rd_data_o = mem_q[rd_index_i];

endmodule

// File: rtl/neighbor_accumulator_buffer.sv
// Banked tile accumulator. Upstream writes are bank-checked and accumulated;
// a drain streams the tile out row-major, zeroing entries as they are read.
//
//   state | meaning
//   CLEAR | sweep zero into every bank index after reset; busy
//   IDLE  | accept per-bank accumulate writes; wait for drain_start
//   DRAIN | stream tile over valid/ready, clear-on-read; busy
module neighbor_accumulator_buffer
    import bitfuscnn_buffer_pkg::*;
#(
    parameter  int BANK_COUNT = DEF_BANK_COUNT,
    parameter  int TILE_SIZE  = DEF_TILE_SIZE,
    parameter  int ACC_WIDTH  = DEF_ACC_WIDTH,
    localparam int ROW_BITS   = $clog2(TILE_SIZE)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [BANK_COUNT-1:0][ROW_BITS-1:0] buffer_row_write,
    input  logic [BANK_COUNT-1:0][ROW_BITS-1:0] buffer_column_write,
    input  logic [BANK_COUNT-1:0][7:0]          buffer_data_write,
    input  logic [BANK_COUNT-1:0]               buffer_write_enable,
    input  logic                                drain_start,
    input  logic                                out_ready,
    output logic                                out_valid,
    output logic [ROW_BITS-1:0]                 out_row,
    output logic [ROW_BITS-1:0]                 out_column,
    output logic signed [ACC_WIDTH-1:0]         out_value,
    output logic                                busy,
    output logic                                drain_done,
    output logic                                bank_error
);

    localparam int N_ENTRIES = TILE_SIZE * TILE_SIZE / BANK_COUNT;
    localparam int IDX_BITS  = $clog2(N_ENTRIES);
    localparam int BANK_BITS = $clog2(BANK_COUNT);
    localparam logic [ROW_BITS-1:0] LAST_RC  = ROW_BITS'(TILE_SIZE - 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_ENTRIES - 1);

    acc_state_t          state_q, state_d;
    logic [IDX_BITS-1:0] clear_idx_q, clear_idx_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [ROW_BITS-1:0] col_q, col_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                        accept;
    logic [BANK_BITS-1:0]        drain_bank;
    logic [IDX_BITS-1:0]         drain_idx;
    logic [BANK_COUNT-1:0]       bad_write;
    logic signed [ACC_WIDTH-1:0] rd_data [BANK_COUNT];

    assign accept     = valid_q & out_ready;
    assign drain_bank = BANK_BITS'(bank_from_rc(int'(row_q), int'(col_q), BANK_COUNT));
    assign drain_idx  = IDX_BITS'(index_from_rc(int'(row_q), int'(col_q), TILE_SIZE, BANK_COUNT));

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        logic [IDX_BITS-1:0] port_idx;
        logic                port_ok;
        logic [IDX_BITS-1:0] wr_index;
        logic                wr_enable;
        logic                wr_zero;

        assign port_ok = bank_from_rc(int'(buffer_row_write[b]), int'(buffer_column_write[b]),
                                      BANK_COUNT) == b;
        assign port_idx = IDX_BITS'(index_from_rc(int'(buffer_row_write[b]),
                                                  int'(buffer_column_write[b]),
                                                  TILE_SIZE, BANK_COUNT));
        assign bad_write[b] = (state_q == IDLE) && buffer_write_enable[b] && !port_ok;

        // Select this bank's write source: clear sweep, upstream accumulate, or clear-on-read
        always_comb begin
            wr_index  = clear_idx_q;
            wr_enable = 1'b0;
            wr_zero   = 1'b1;
            case (state_q)
                CLEAR: wr_enable = 1'b1;
                IDLE: begin
                    wr_index  = port_idx;
                    wr_enable = buffer_write_enable[b] && port_ok;
                    wr_zero   = 1'b0;
                end
                DRAIN: begin
                    wr_index  = drain_idx;
                    wr_enable = accept && (drain_bank == BANK_BITS'(b));
                end
                default: wr_enable = 1'b0;
            endcase
        end

        accumulator_bank #(
            .ENTRY_COUNT (N_ENTRIES),
            .INDEX_W     (IDX_BITS),
            .ACC_WIDTH   (ACC_WIDTH)
        ) u_bank (
            .clk_i       (clk),
            .wr_index_i  (wr_index),
            .wr_data_i   (buffer_data_write[b]),
            .wr_enable_i (wr_enable),
            .wr_zero_i   (wr_zero),
            .rd_index_i  (drain_idx),
            .rd_data_o   (rd_data[b])
        );
    end

    // Sequencing: clear sweep, idle accumulate, row-major drain
    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        row_d       = row_q;
        col_d       = col_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        err_d       = err_q | (|bad_write);
        case (state_q)
            CLEAR: begin
                clear_idx_d = clear_idx_q + 1'b1;
                if (clear_idx_q == LAST_IDX) begin
                    state_d     = IDLE;
                    clear_idx_d = '0;
                end
            end
            IDLE: begin
                if (drain_start) begin
                    state_d = DRAIN;
                    row_d   = '0;
                    col_d   = '0;
                    valid_d = 1'b1;
                end
            end
            DRAIN: begin
                if (accept) begin
                    col_d = col_q + 1'b1;
                    if (col_q == LAST_RC) begin
                        row_d = row_q + 1'b1;
                        if (row_q == LAST_RC) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Control registers; reset restarts the clear sweep from any state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            clear_idx_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_row    = row_q;
    assign out_column = col_q;
    assign out_value  = rd_data[drain_bank];
    assign busy       = (state_q != IDLE);
    assign drain_done = done_q;
    assign bank_error = err_q;

endmodule
